// File: rtl/char_overlay_ctrl_if.sv
// Port bundle for char_overlay_ctrl: control (enable, text writes), video in/out
// and the glyph ROM bus.
interface char_overlay_ctrl_if #(
    parameter int CHAR_NUM       = 8,
    parameter int CODE_WIDTH     = 4,
    parameter int ROM_ADDR_WIDTH = 8
);
    logic                        enable;
    logic                        txt_we;
    logic [$clog2(CHAR_NUM)-1:0] txt_waddr;
    logic [CODE_WIDTH-1:0]       txt_wdata;
    logic                        i_vsync;
    logic                        i_hsync;
    logic                        i_de;
    logic [23:0]                 i_data;
    logic [ROM_ADDR_WIDTH-1:0]   rom_raddr;
    logic [7:0]                  rom_rdata;
    logic                        o_vsync;
    logic                        o_hsync;
    logic                        o_de;
    logic [23:0]                 o_data;
    logic                        active;

    // No handshake: video is one pixel per clock qualified by i_de, text writes
    // take effect on the edge where txt_we is high, ROM data is combinational.
    modport slave (
        input  enable, txt_we, txt_waddr, txt_wdata,
        input  i_vsync, i_hsync, i_de, i_data, rom_rdata,
        output rom_raddr, o_vsync, o_hsync, o_de, o_data, active
    );

    modport master (
        output enable, txt_we, txt_waddr, txt_wdata,
        output i_vsync, i_hsync, i_de, i_data, rom_rdata,
        input  rom_raddr, o_vsync, o_hsync, o_de, o_data, active
    );
endinterface

// File: rtl/char_overlay_ctrl.sv
// Overlays a CHAR_NUM-character string from an 8-pixel-wide glyph ROM onto an
// RGB888 stream with a fixed 2-clock latency; the text buffer is committed at frame start.
module char_overlay_ctrl #(
    parameter int          H_START        = 100,
    parameter int          V_START        = 100,
    parameter int          CHAR_NUM       = 8,
    parameter int          CHAR_H         = 16,
    parameter int          CODE_WIDTH     = 4,
    parameter int          ROM_ADDR_WIDTH = 8,
    parameter logic [23:0] FG_COLOR       = 24'hFFFFFF
) (
    input logic                 clk,
    input logic                 rst_n,
    char_overlay_ctrl_if.slave  bus
);
    localparam int IDX_W = $clog2(CHAR_NUM);
    localparam int ROW_W = $clog2(CHAR_H);
    localparam logic [12:0] H_LO = 13'(H_START);
    localparam logic [12:0] H_HI = 13'(H_START + 8 * CHAR_NUM);
    localparam logic [12:0] V_LO = 13'(V_START);
    localparam logic [12:0] V_HI = 13'(V_START + CHAR_H);
    // Only the low bits of the offsets are needed for idx/col/row.
    localparam logic [IDX_W+2:0] H_OFF = (IDX_W + 3)'(H_START);
    localparam logic [ROW_W-1:0] V_OFF = ROW_W'(V_START);

    typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

    state_t state_q, state_d;
    logic   vs_prev_q, vs_prev_d;
    logic   de_prev_q, de_prev_d;
    logic [11:0] x_cnt_q, x_cnt_d;
    logic [11:0] y_cnt_q, y_cnt_d;
    logic [CHAR_NUM-1:0][CODE_WIDTH-1:0] shadow_q, shadow_d;
    logic [CHAR_NUM-1:0][CODE_WIDTH-1:0] live_q, live_d;

    logic [ROM_ADDR_WIDTH-1:0] rom_raddr_q, rom_raddr_d;
    logic [2:0]  s1_col_q, s1_col_d;
    logic        s1_in_win_q, s1_in_win_d;
    logic        s1_vs_q, s1_vs_d, s1_hs_q, s1_hs_d, s1_de_q, s1_de_d;
    logic [23:0] s1_data_q, s1_data_d;
    logic        o_vs_q, o_vs_d, o_hs_q, o_hs_d, o_de_q, o_de_d;
    logic [23:0] o_data_q, o_data_d;

    logic             fs, de_fall, in_win, pix_on;
    logic [IDX_W+2:0] dx;
    logic [ROW_W-1:0] dy;

    always_comb begin
        fs      = bus.i_vsync & ~vs_prev_q;
        de_fall = ~bus.i_de & de_prev_q;
        vs_prev_d = bus.i_vsync;
        de_prev_d = bus.i_de;

        x_cnt_d = x_cnt_q;
        if (bus.i_de) begin
            if (x_cnt_q != 12'hFFF) x_cnt_d = x_cnt_q + 12'd1;
        end else if (de_fall) begin
            x_cnt_d = 12'd0;
        end

        y_cnt_d = y_cnt_q;
        if (fs) begin
            y_cnt_d = 12'd0;
        end else if (de_fall && (y_cnt_q != 12'hFFF)) begin
            y_cnt_d = y_cnt_q + 12'd1;
        end

        // live copies the pre-write shadow, so a write on the fs edge lands a frame later
        shadow_d = shadow_q;
        if (bus.txt_we) shadow_d[bus.txt_waddr] = bus.txt_wdata;
        live_d = fs ? shadow_q : live_q;

        state_d = state_q;
        case (state_q)
            IDLE:    if (fs && bus.enable)  state_d = SHOW;
            SHOW:    if (fs && !bus.enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_win = (state_q == SHOW) && bus.i_de
              && ({1'b0, x_cnt_q} >= H_LO) && ({1'b0, x_cnt_q} < H_HI)
              && ({1'b0, y_cnt_q} >= V_LO) && ({1'b0, y_cnt_q} < V_HI);
        dx = x_cnt_q[IDX_W+2:0] - H_OFF;
        dy = y_cnt_q[ROW_W-1:0] - V_OFF;

        rom_raddr_d = in_win ? {live_q[dx[IDX_W+2:3]], dy} : rom_raddr_q;
        s1_col_d    = dx[2:0];
        s1_in_win_d = in_win;
        s1_vs_d     = bus.i_vsync;
        s1_hs_d     = bus.i_hsync;
        s1_de_d     = bus.i_de;
        s1_data_d   = bus.i_data;

        pix_on   = s1_in_win_q & bus.rom_rdata[3'd7 - s1_col_q];
        o_data_d = pix_on ? FG_COLOR : s1_data_q;
        o_vs_d   = s1_vs_q;
        o_hs_d   = s1_hs_q;
        o_de_d   = s1_de_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vs_prev_q   <= 1'b0;
            de_prev_q   <= 1'b0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            shadow_q    <= '0;
            live_q      <= '0;
            rom_raddr_q <= '0;
            s1_col_q    <= '0;
            s1_in_win_q <= 1'b0;
            s1_vs_q     <= 1'b0;
            s1_hs_q     <= 1'b0;
            s1_de_q     <= 1'b0;
            s1_data_q   <= '0;
            o_vs_q      <= 1'b0;
            o_hs_q      <= 1'b0;
            o_de_q      <= 1'b0;
            o_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            vs_prev_q   <= vs_prev_d;
            de_prev_q   <= de_prev_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            shadow_q    <= shadow_d;
            live_q      <= live_d;
            rom_raddr_q <= rom_raddr_d;
            s1_col_q    <= s1_col_d;
            s1_in_win_q <= s1_in_win_d;
            s1_vs_q     <= s1_vs_d;
            s1_hs_q     <= s1_hs_d;
            s1_de_q     <= s1_de_d;
            s1_data_q   <= s1_data_d;
            o_vs_q      <= o_vs_d;
            o_hs_q      <= o_hs_d;
            o_de_q      <= o_de_d;
            o_data_q    <= o_data_d;
        end
    end

    assign bus.rom_raddr = rom_raddr_q;
    assign bus.o_vsync   = o_vs_q;
    assign bus.o_hsync   = o_hs_q;
    assign bus.o_de      = o_de_q;
    assign bus.o_data    = o_data_q;
    assign bus.active    = (state_q == SHOW);
endmodule

// File: doc/char_overlay_ctrl.md
Name: char_overlay_ctrl

Overview:
- Sequences reads from the 8-pixel-wide glyph ROM (combinational read, 1 byte per glyph row) to overlay a text string on a passing RGB video stream.
- Holds a small double-buffered text buffer of character codes, written by a control interface and committed at frame start.
- Tracks pixel position, addresses the ROM and keys the foreground colour over the video with a fixed 2-cycle pipeline.

Parameters:
- H_START, 100, first overlay column (active-pixel index)
- V_START, 100, first overlay line (active-line index)
- CHAR_NUM, 8, characters in the string; power of 2, 2..16
- CHAR_H, 16, glyph height in lines; power of 2
- CODE_WIDTH, 4, character-code width
- ROM_ADDR_WIDTH, 8, must equal CODE_WIDTH + log2(CHAR_H)
- FG_COLOR, 24'hFFFFFF, overlay foreground colour

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  overlay request; sampled at frame start only
- txt_we  in  1  text buffer write strobe
- txt_waddr  in  log2(CHAR_NUM)  character slot to write
- txt_wdata  in  CODE_WIDTH  character code
- i_vsync  in  1  input vsync, active high
- i_hsync  in  1  input hsync, active high
- i_de  in  1  input data enable
- i_data  in  24  input RGB888
- rom_raddr  out  ROM_ADDR_WIDTH  glyph ROM address, {code, row}
- rom_rdata  in  8  glyph row; bit 7 = leftmost pixel; valid combinationally from rom_raddr
- o_vsync, o_hsync, o_de  out  1 each  delayed sync/enable
- o_data  out  24  output RGB888
- active  out  1  1 while the FSM is in SHOW

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Shadow and live text buffers all 0.
  - x_cnt = y_cnt = 0.
- Frame start (fs) is the vsync rising edge: i_vsync = 1 while the registered previous vsync = 0.
- Counters, 12-bit, both saturate at 4095:
  - x_cnt increments on each i_de = 1 cycle and clears on each i_de falling edge.
  - y_cnt increments on each i_de falling edge and clears on fs.
- Text buffer:
  - txt_we writes the shadow slot txt_waddr on the same clock edge.
  - On fs, shadow is copied into live.
  - If txt_we coincides with fs, live receives the pre-write shadow value; the new code appears one frame later.
  - Live never changes mid-frame.
- FSM:
  - IDLE: on fs with enable = 1, go to SHOW. Otherwise stay.
  - SHOW: on fs with enable = 0, go to IDLE. Otherwise stay.
  - Changes of enable between frame starts have no effect.
- Window: in_win is true when all of the following hold:
  - FSM = SHOW and i_de = 1
  - H_START <= x_cnt < H_START + 8*CHAR_NUM
  - V_START <= y_cnt < V_START + CHAR_H
  - The comparisons use the pre-increment counter values of the current cycle.
- Stage 1 (registered):
  - dx = x_cnt - H_START; idx = dx >> 3; col = dx[2:0]; row = y_cnt - V_START (low log2(CHAR_H) bits).
  - rom_raddr <= {live[idx], row}, updated only when in_win; otherwise it holds its value.
  - col, in_win, the sync signals and i_data are registered alongside.
- Stage 2 (registered):
  - o_data <= (in_win_d1 and rom_rdata[7 - col_d1]) ? FG_COLOR : i_data_d1.
  - o_vsync, o_hsync and o_de are delayed by exactly 2 cycles.
- Latency: exactly 2 clocks from input to output for every signal, in both IDLE and SHOW. Outside the window the pixel passes through unchanged (transparent background).
- Window edge cases:
  - A window partly beyond the active area is clipped naturally.
  - A window entirely beyond the active area means pure passthrough.
  - No wrap of idx beyond CHAR_NUM - 1.
- Reset mid-frame clears all state immediately. The output is passthrough-free zeros until the pipeline refills. Overlay resumes only after the next fs with enable = 1.

Test Plan:
Bench setup: 64x32 active frame, H_START = 8, V_START = 4, CHAR_NUM = 4, CHAR_H = 16, ROM model with glyph 1 row r = 8'hA5 for all r and glyph 0 = 8'h00.
- Passthrough: enable = 0, i_data = 24'h123456 ramp -> o_data equals i_data delayed 2 clocks, syncs delayed 2, active = 0.
- Basic overlay:
  - Stimulus: write slots 0..3 = 1, enable = 1, run 2 frames.
  - Frame 2, line 4, x = 8..15 -> o_data = FFFFFF, in, FFFFFF, in, in, FFFFFF, in, FFFFFF (in = i_data).
  - Line 20 (y = V_START + CHAR_H) is untouched.
- Window bounds: check x = 7, x = 40 and y = 3 -> passthrough; x = 39 on line 19 -> bit 0 of glyph (FFFFFF); rom_raddr = {4'd1, 4'd15} at line 19.
- Double buffering:
  - Stimulus: change slot 2 to code 0 mid-frame in frame N.
  - Frame N shows glyph 1 at x = 24..31; frame N+1 shows background there.
  - Write coincident with fs shows the new code in frame N+2.
- Enable timing:
  - Stimulus: deassert enable mid-frame.
  - Overlay continues to the end of the frame; active drops at the next fs; the following frame is pure passthrough.
- Reset mid-line: assert rst_n = 0 during the window -> all outputs 0 asynchronously, FSM in IDLE; after release, live buffer = 0 and no overlay until fs with enable = 1.
